// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce filter.
//   state_e               : 2-bit FSM encoding (stable high/low, qualifying low/high)
//   DefaultDebounceCycles : default number of consecutive samples needed to accept a new level
//   DefaultCntW           : default stability counter width
//   stable_state()        : maps a line level to the matching stable state
package debounce_pkg;

  typedef enum logic [1:0] {
    StHigh  = 2'b00,
    ChkLow  = 2'b01,
    StLow   = 2'b10,
    ChkHigh = 2'b11
  } state_e;

  localparam int unsigned DefaultDebounceCycles = 4;
  localparam int unsigned DefaultCntW           = 16;

  function automatic state_e stable_state(input logic level);
    return level ? StHigh : StLow;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : sampling clock (rising edge)
//   rst : asynchronous active-high reset, loads both flops with RESET_VALUE
//   d   : asynchronous input
//   q   : synchronized output, two edges behind d
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/debounce_filter.sv
// Debounce filter: accepts a new level on `in` only after it has been sampled
// DEBOUNCE_CYCLES consecutive times; any contrary sample restarts qualification.
//   clk  : system clock (rising edge)
//   rst  : asynchronous active-high reset
//   in   : raw, bouncing line
//   out  : registered debounced level (IDLE_LEVEL after reset)
//   busy : registered, high while a level change is being qualified
// Build option: define DEBOUNCE_FILTER_SYNC_EN to put a two-flop synchronizer
// in front of the filter (adds two edges of latency). Without it, `in` must
// already be synchronous to clk.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_W           = DefaultCntW,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy
);

  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam state_e           IdleState = stable_state(IDLE_LEVEL);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;

`ifdef DEBOUNCE_FILTER_SYNC_EN
  sync_2ff #(
    .RESET_VALUE(IDLE_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in),
    .q  (s)
  );
`else
  assign s = in;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StHigh: begin
        if (!s) begin
          state_d = ChkLow;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      ChkLow: begin
        if (s) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          // >= rather than == so a corrupted count can never wrap
          state_d = StLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLow: begin
        if (s) begin
          state_d = ChkHigh;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      ChkHigh: begin
        if (!s) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = IdleState;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they change on the accepting edge
    out_d  = (state_d == StHigh) || (state_d == ChkLow);
    busy_d = (state_d == ChkLow) || (state_d == ChkHigh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IdleState;
      cnt_q   <= '0;
      out_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Self-checking bench for debounce_filter (DEBOUNCE_CYCLES=4, IDLE_LEVEL=1).
// Includes a falling-edge detector on out as the downstream consumer.
module tb_debounce_filter;

  localparam int   D    = 4;
  localparam logic IDLE = 1'b1;
`ifdef DEBOUNCE_FILTER_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout;
  logic dbusy;

  always #5 clk = ~clk;

  debounce_filter #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16),
    .IDLE_LEVEL     (IDLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout),
    .busy(dbusy)
  );

  // Downstream falling-edge detector
  logic det_prev;
  logic det_pulse;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) det_prev <= IDLE;
    else     det_prev <= dout;
  end
  assign det_pulse = det_prev & ~dout;

  int checks = 0;
  int passes = 0;
  int det_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: count consecutive samples that disagree with the accepted level
  logic m_out;
  int   m_run;
  logic m_pipe[2];
  int   m_falls;

  function automatic void model_reset();
    m_out     = IDLE;
    m_run     = 0;
    m_pipe[0] = IDLE;
    m_pipe[1] = IDLE;
  endfunction

  function automatic void model_edge(input logic v);
    logic s;
    if (SYNC_STAGES == 2) begin
      s         = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = v;
    end else begin
      s = v;
    end
    if (s != m_out) begin
      m_run++;
      if (m_run == D) begin
        if (!s) m_falls++;
        m_out = s;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endfunction

  task automatic tick(input logic v);
    din = v;
    @(posedge clk);
    model_edge(v);
    #1;
    if (det_pulse) det_count++;
    check("model_out", dout, m_out);
    check("model_busy", dbusy, (m_run != 0));
  endtask

  typedef struct {
    logic in;
    logic out;
    logic busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic i, input logic o, input logic b);
    vec_t v;
    v.in = i; v.out = o; v.busy = b;
    tbl.push_back(v);
  endfunction

  initial begin
    int   falls_before;
    logic prev_exp;

    m_falls = 0;
    rst = 1'b1;
    din = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", dout, IDLE);
    check("reset_busy", dbusy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

`ifndef DEBOUNCE_FILTER_SYNC_EN
    // Clean fall, clean rise, glitch, bounce-then-settle, rise
    add(1, 1, 0);
    add(0, 1, 1); add(0, 1, 1); add(0, 1, 1); add(0, 0, 0); add(0, 0, 0);
    add(1, 0, 1); add(1, 0, 1); add(1, 0, 1); add(1, 1, 0); add(1, 1, 0);
    add(0, 1, 1); add(0, 1, 1); add(0, 1, 1); add(1, 1, 0); add(1, 1, 0);
    add(0, 1, 1); add(1, 1, 0); add(0, 1, 1); add(0, 1, 1); add(1, 1, 0);
    add(0, 1, 1); add(0, 1, 1); add(0, 1, 1); add(0, 0, 0);
    add(1, 0, 1); add(1, 0, 1); add(1, 0, 1); add(1, 1, 0);
    prev_exp = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].in);
      check($sformatf("tbl_out[%0d]", i), dout, tbl[i].out);
      check($sformatf("tbl_busy[%0d]", i), dbusy, tbl[i].busy);
      check($sformatf("tbl_pulse[%0d]", i), det_pulse, prev_exp & ~tbl[i].out);
      prev_exp = tbl[i].out;
    end

    // Glitch: three lows then high must leave nothing behind
    falls_before = det_count;
    for (int i = 0; i < 3; i++) tick(1'b0);
    tick(1'b1);
    check("glitch_out", dout, 1'b1);
    check("glitch_busy", dbusy, 1'b0);
    check("glitch_cnt", dut.cnt_q, 0);
    check("glitch_pulses", det_count, falls_before);
`else
    // Synchronizer latency: out falls on the 6th edge after in is first sampled low
    for (int i = 0; i < 3; i++) tick(1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0);
      check($sformatf("sync_out[%0d]", i), dout, (i < 6));
    end
    for (int i = 0; i < D + SYNC_STAGES; i++) tick(1'b1);
    check("sync_rise_out", dout, 1'b1);
`endif

    // Reset in the middle of a qualification
    for (int i = 0; i < 2 + SYNC_STAGES; i++) tick(1'b0);
    check("pre_rst_cnt", dut.cnt_q, 2);
    check("pre_rst_busy", dbusy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", dout, 1'b1);
    check("mid_rst_busy", dbusy, 1'b0);
    check("mid_rst_cnt", dut.cnt_q, 0);
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < D + SYNC_STAGES - 1; i++) begin
      tick(1'b0);
      check($sformatf("post_rst_hold[%0d]", i), dout, 1'b1);
    end
    tick(1'b0);
    check("post_rst_fall", dout, 1'b0);

    // Randomized runs of varying length
    for (int b = 0; b < 80; b++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) tick(v);
    end

    check("detector_pulses", det_count, m_falls);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the consecutive sampling edges a new level must persist before it is accepted; legal range 2..2**CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the stability counter width.
REQ-003 SHALL have parameter IDLE_LEVEL, default 1'b1, meaning the value of out after reset (idle-high line).
REQ-004 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning the reset; it is asynchronous and active-high.
REQ-006 SHALL have port in, input, 1 bit, meaning the raw, bouncing, possibly asynchronous line.
REQ-007 SHALL have port out, output, 1 bit, registered, meaning the debounced level; it directly drives the downstream falling-edge detector's in.
REQ-008 SHALL have port busy, output, 1 bit, registered, meaning a level change is being qualified.

Function
REQ-009 SHALL sample s = synchronized in (see REQ-020) or raw in on every rising clk edge.
REQ-010 SHALL implement four states: ST_HIGH, CHK_LOW, ST_LOW, CHK_HIGH.
REQ-011 SHALL in ST_HIGH with s=0 go to CHK_LOW and load cnt=1; otherwise hold with cnt=0.
REQ-012 SHALL in CHK_LOW with s=0 and cnt<DEBOUNCE_CYCLES-1 increment cnt; with s=0 and cnt=DEBOUNCE_CYCLES-1 go to ST_LOW, set out=0 and clear cnt; with s=1 return to ST_HIGH and clear cnt, leaving out=1.
REQ-013 SHALL mirror REQ-011/012 for ST_LOW/CHK_HIGH with polarities swapped.
REQ-014 SHALL therefore change out at the DEBOUNCE_CYCLES-th consecutive sampling edge of the new level; any single contrary sample restarts qualification.
REQ-015 SHALL assert busy exactly while in CHK_LOW or CHK_HIGH.
REQ-016 SHALL route any illegal state encoding to the stable state matching IDLE_LEVEL on the next edge.
REQ-017 SHALL never let cnt wrap; cnt stays at or below DEBOUNCE_CYCLES-1.

Reset
REQ-018 SHALL, while rst=1 and regardless of clk, force state to ST_HIGH if IDLE_LEVEL=1 or ST_LOW if IDLE_LEVEL=0, with cnt=0, out=IDLE_LEVEL, busy=0, and synchronizer flops=IDLE_LEVEL.
REQ-019 SHALL abandon any qualification in progress when rst asserts mid-operation; after release, counting restarts from zero.

Configuration
REQ-020 SHALL, with macro DEBOUNCE_FILTER_SYNC_EN defined, insert a two-flop synchronizer on in, so s lags in by 2 edges and total latency is DEBOUNCE_CYCLES+2 edges.
REQ-021 SHALL, without DEBOUNCE_FILTER_SYNC_EN, use s=in directly, giving a latency of DEBOUNCE_CYCLES edges; in must then be synchronous to clk.

Structure
REQ-022 SHALL place the state encodings (2-bit ST_HIGH=00, CHK_LOW=01, ST_LOW=10, CHK_HIGH=11) and default DEBOUNCE_CYCLES/CNT_W constants in shared package debounce_pkg.
REQ-023 SHALL implement the synchronizer as sub-module sync_2ff (clk, rst, reset value parameter, d, q), instantiated only under DEBOUNCE_FILTER_SYNC_EN.

Verification (DEBOUNCE_CYCLES=4, IDLE_LEVEL=1, macro undefined unless stated)
REQ-024 SHALL test a clean fall: in held 0 from edge k -> busy=1 after edge k, out=0 after edge k+3, busy=0 after edge k+3.
REQ-025 SHALL test a glitch: in=0 for 3 edges then 1 -> out stays 1 throughout, busy returns to 0 and cnt to 0.
REQ-026 SHALL test bounce-then-settle: in pattern 0,1,0,0,1,0,0,0,0 -> out falls only at the 4th of the final four 0 samples.
REQ-027 SHALL test reset mid-qualification: rst pulsed asynchronously between edges during CHK_LOW with cnt=2 -> out=1, busy=0 immediately; a following 4-cycle low is required to fall.
REQ-028 SHALL test sync latency with DEBOUNCE_FILTER_SYNC_EN defined: a clean fall of in -> out=0 exactly 6 edges after in is first sampled low.
REQ-029 SHALL test the downstream chain: out feeding the falling-edge detector -> exactly one detector pulse per qualified fall and none for REQ-025 glitches.
